// File: rtl/bomberman_pkg.sv
// Shared constants and types for the bomberman video path: colour format,
// background/key colours and the priority order of the compositor layers.
package bomberman_pkg;

  localparam int unsigned COLOR_W = 12;

  localparam logic [COLOR_W-1:0] BG_COLOR  = 12'h69C;
  localparam logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F;

  // Layer indices, lowest index wins
  localparam int unsigned L_PLAYER = 0;
  localparam int unsigned L_BOX    = 1;
  localparam int unsigned L_ENEMY  = 2;
  localparam int unsigned L_BOMB   = 3;
  localparam int unsigned L_EXPL   = 4;
  localparam int unsigned L_WALL   = 5;

  typedef struct packed {
    logic bright;
    logic hsync;
    logic vsync;
  } sync_t;

endpackage

// File: rtl/layer_priority_sel.sv
// Combinational priority select: colour of the lowest-index visible layer,
// plus a flag telling whether any layer is visible at all.
module layer_priority_sel #(
  parameter int unsigned N_LAYERS = 6,
  parameter int unsigned COLOR_W  = 12
) (
  input  logic [N_LAYERS-1:0]         vis,
  input  logic [N_LAYERS*COLOR_W-1:0] rgb,
  output logic                        any_c,
  output logic [COLOR_W-1:0]          color_c
);

  // Scan from lowest priority upward so the highest-priority hit is assigned last
  always_comb begin
    any_c   = |vis;
    color_c = '0;
    for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
      if (vis[i]) color_c = rgb[i*COLOR_W +: COLOR_W];
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor: colour keying, per-frame layer mask, blinking,
// player-overlap recording, two registered stages with matching sync delay.
module layer_compositor
  import bomberman_pkg::*;
#(
  parameter int unsigned          N_LAYERS  = 6,
  parameter int unsigned          COLOR_W   = bomberman_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0]   BG_COLOR  = bomberman_pkg::BG_COLOR,
  parameter bit                   KEY_EN    = 1'b1,
  parameter logic [COLOR_W-1:0]   KEY_COLOR = bomberman_pkg::KEY_COLOR,
  parameter int unsigned          BLINK_BIT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bright,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [N_LAYERS-1:0]         layer_on,
  input  logic [N_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic                        mask_wr,
  input  logic [N_LAYERS-1:0]         mask_in,
  input  logic [N_LAYERS-1:0]         blink_mask,
  output logic [COLOR_W-1:0]          rgb_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic [N_LAYERS-1:0]         collision,
  output logic [15:0]                 frame_cnt
);

  sync_t                       s1;
  logic [N_LAYERS-1:0]         on_s1;
  logic [N_LAYERS*COLOR_W-1:0] rgb_s1;
  logic [N_LAYERS-1:0]         shadow_mask;
  logic [N_LAYERS-1:0]         active_mask;
  logic [N_LAYERS-1:0]         acc;
  logic [N_LAYERS-1:0]         vis;
  logic [N_LAYERS-1:0]         hit;
  logic                        frame_tick;
  logic                        any_vis;
  logic [COLOR_W-1:0]          top_color;

  // Stage 1: capture the pixel and its timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '{bright: 1'b0, hsync: 1'b1, vsync: 1'b1};
      on_s1  <= '0;
      rgb_s1 <= '0;
    end else begin
      s1     <= '{bright: bright, hsync: hsync_in, vsync: vsync_in};
      on_s1  <= layer_on;
      rgb_s1 <= layer_rgb;
    end
  end

  // Per-layer visibility after mask, blink phase and colour key
  always_comb begin
    vis = '0;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      vis[i] = on_s1[i] & active_mask[i]
             & ~(blink_mask[i] & frame_cnt[BLINK_BIT])
             & ~(KEY_EN & (rgb_s1[i*COLOR_W +: COLOR_W] == KEY_COLOR));
    end
  end

  // Overlap with the player; bit 0 never records
  always_comb begin
    hit = '0;
    for (int unsigned i = 1; i < N_LAYERS; i++) begin
      hit[i] = s1.bright & vis[L_PLAYER] & vis[i];
    end
  end

  // vsync_out is the S1 vsync one cycle later, so this is the S1 falling edge
  assign frame_tick = vsync_out & ~s1.vsync;

  layer_priority_sel #(
    .N_LAYERS (N_LAYERS),
    .COLOR_W  (COLOR_W)
  ) u_sel (
    .vis     (vis),
    .rgb     (rgb_s1),
    .any_c   (any_vis),
    .color_c (top_color)
  );

  // Stage 2: final colour and delayed syncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= s1.hsync;
      vsync_out <= s1.vsync;
      if (!s1.bright)   rgb_out <= '0;
      else if (any_vis) rgb_out <= top_color;
      else              rgb_out <= BG_COLOR;
    end
  end

  // Frame-boundary state: mask swap, frame counter, collision publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_mask <= '1;
      active_mask <= '1;
      acc         <= '0;
      collision   <= '0;
      frame_cnt   <= '0;
    end else begin
      if (mask_wr) shadow_mask <= mask_in;
      if (frame_tick) begin
        active_mask <= mask_wr ? mask_in : shadow_mask;
        frame_cnt   <= frame_cnt + 16'd1;
        collision   <= acc | hit;
        acc         <= '0;
      end else begin
        acc <= acc | hit;
      end
    end
  end

endmodule
